// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding command to Wishbone classic master.
// Optional bus timeout: define WB_MASTER_TIMEOUT_EN.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; payload we/adr/dat/sel
//   rsp_valid/ready     response handshake; payload dat/err/timeout
//   wishbone_*          Wishbone classic master (single beat)
//   busy                high whenever not idle
//
// Parameter:
//   TIMEOUT_CYCLES      bus cycles before abort (1..65535), only
//                       used when WB_MASTER_TIMEOUT_EN is defined

module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,

  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_dat_w,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_we,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic [31:0] wishbone_dat_r,
  input  logic        wishbone_ack,
  input  logic        wishbone_err,

  output logic        busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("wb_cmd_master: TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;

  // Classic single-beat cycles only.
  assign wishbone_cti = 3'b000;
  assign wishbone_bte = 2'b00;

  logic tmo_only;
  logic bus_end;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  // Counter holds the number of BUS cycles already completed,
  // so the abort lands after exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit  = (tmo_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);
  // Any slave answer in the same cycle beats the timeout.
  assign tmo_only = tmo_hit & ~wishbone_ack & ~wishbone_err;
`else
  assign tmo_only    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign bus_end = wishbone_ack | wishbone_err | tmo_only;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      wishbone_cyc   <= 1'b0;
      wishbone_stb   <= 1'b0;
      wishbone_we    <= 1'b0;
      wishbone_adr   <= '0;
      wishbone_dat_w <= '0;
      wishbone_sel   <= '0;
      rsp_valid      <= 1'b0;
      rsp_dat        <= '0;
      rsp_err        <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_timeout    <= 1'b0;
      tmo_cnt        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            state          <= BUS;
            cmd_ready      <= 1'b0;
            busy           <= 1'b1;
            wishbone_cyc   <= 1'b1;
            wishbone_stb   <= 1'b1;
            wishbone_we    <= cmd_we;
            wishbone_adr   <= cmd_adr;
            wishbone_dat_w <= cmd_dat;
            wishbone_sel   <= cmd_sel;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
          end
        end

        BUS: begin
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 16'd1;
`endif
          if (bus_end) begin
            state          <= RESP;
            wishbone_cyc   <= 1'b0;
            wishbone_stb   <= 1'b0;
            wishbone_we    <= 1'b0;
            wishbone_adr   <= '0;
            wishbone_dat_w <= '0;
            wishbone_sel   <= '0;
            rsp_valid      <= 1'b1;
            rsp_err        <= wishbone_err | tmo_only;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_timeout    <= tmo_only;
`endif
            // Data only on a clean read ack; err wins over ack.
            if (wishbone_ack && !wishbone_err && !wishbone_we)
              rsp_dat <= wishbone_dat_r;
            else
              rsp_dat <= '0;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed bench with a transaction-level model
// checked every cycle, plus literal expectations per scenario.

module tb_wb_cmd_master;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [29:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_dat_w;
  logic [3:0]  wishbone_sel;
  logic        wishbone_we;
  logic        wishbone_cyc;
  logic        wishbone_stb;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;
  logic [31:0] wishbone_dat_r;
  logic        wishbone_ack;
  logic        wishbone_err;
  logic        busy;

  wb_cmd_master #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we(cmd_we),
    .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat),
    .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .wishbone_adr(wishbone_adr),
    .wishbone_dat_w(wishbone_dat_w),
    .wishbone_sel(wishbone_sel),
    .wishbone_we(wishbone_we),
    .wishbone_cyc(wishbone_cyc),
    .wishbone_stb(wishbone_stb),
    .wishbone_cti(wishbone_cti),
    .wishbone_bte(wishbone_bte),
    .wishbone_dat_r(wishbone_dat_r),
    .wishbone_ack(wishbone_ack),
    .wishbone_err(wishbone_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
  } rsp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  int   beats   = 0;
  int   b0;
  int   ncyc;
  int   nrv;

  // Model: one accepted command on the bus, then one queued response.
  bit   m_act = 1'b0;
  int   m_cyc = 0;
  cmd_t m_cmd;
  rsp_t m_q[$];
  rsp_t m_r;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      m_cyc = 0;
      m_q.delete();
    end else if (m_q.size() != 0) begin
      if (rsp_ready) void'(m_q.pop_front());
    end else if (m_act) begin
      m_cyc++;
      if (wishbone_err) begin
        m_r = '{32'h0, 1'b1, 1'b0};
        m_q.push_back(m_r);
        m_act = 1'b0;
      end else if (wishbone_ack) begin
        m_r.dat = m_cmd.we ? 32'h0 : wishbone_dat_r;
        m_r.err = 1'b0;
        m_r.tmo = 1'b0;
        m_q.push_back(m_r);
        m_act = 1'b0;
      end
`ifdef WB_MASTER_TIMEOUT_EN
      else if (m_cyc == TMO) begin
        m_r = '{32'h0, 1'b1, 1'b1};
        m_q.push_back(m_r);
        m_act = 1'b0;
      end
`endif
    end else if (cmd_valid) begin
      m_act = 1'b1;
      m_cyc = 0;
      m_cmd = '{cmd_we, cmd_adr, cmd_dat, cmd_sel};
    end
  end

  always @(posedge clk)
    if (!reset && rsp_valid && rsp_ready) beats++;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_cmd_ready", 32'(cmd_ready),
            32'(!m_act && m_q.size() == 0));
      check("m_busy", 32'(busy),
            32'(m_act || m_q.size() != 0));
      check("m_cyc", 32'(wishbone_cyc), 32'(m_act));
      check("m_stb", 32'(wishbone_stb), 32'(m_act));
      check("m_we", 32'(wishbone_we),
            32'(m_act && m_cmd.we));
      check("m_adr", 32'(wishbone_adr),
            m_act ? 32'(m_cmd.adr) : 32'h0);
      check("m_dat_w", wishbone_dat_w,
            m_act ? m_cmd.dat : 32'h0);
      check("m_sel", 32'(wishbone_sel),
            m_act ? 32'(m_cmd.sel) : 32'h0);
      check("m_cti_bte",
            32'({wishbone_cti, wishbone_bte}), 32'h0);
      check("m_rsp_valid", 32'(rsp_valid),
            32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("m_rsp_dat", rsp_dat, m_q[0].dat);
        check("m_rsp_err", 32'(rsp_err), 32'(m_q[0].err));
        check("m_rsp_tmo", 32'(rsp_timeout),
              32'(m_q[0].tmo));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first cyc cycle.
  task automatic send(input logic we, input logic [29:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    cmd_valid      = 1'b0;
    cmd_we         = 1'b0;
    cmd_adr        = '0;
    cmd_dat        = '0;
    cmd_sel        = '0;
    rsp_ready      = 1'b0;
    wishbone_dat_r = '0;
    wishbone_ack   = 1'b0;
    wishbone_err   = 1'b0;

    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cyc", 32'(wishbone_cyc), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_adr", 32'(wishbone_adr), 32'h0);

    // Stray err while idle is ignored.
    wishbone_err = 1'b1;
    @(negedge clk);
    wishbone_err = 1'b0;
    check("idle_err_cyc", 32'(wishbone_cyc), 32'h0);
    check("idle_err_rv", 32'(rsp_valid), 32'h0);

    // Read, slave acks on its second cyc cycle.
    send(1'b0, 30'h100, 32'h0, 4'hF);
    check("rd_cyc1", 32'(wishbone_cyc), 32'h1);
    check("rd_adr", 32'(wishbone_adr), 32'h100);
    check("rd_we", 32'(wishbone_we), 32'h0);
    check("rd_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    check("rd_cyc2", 32'(wishbone_cyc), 32'h1);
    wishbone_ack   = 1'b1;
    wishbone_dat_r = 32'hDEADBEEF;
    @(negedge clk);
    wishbone_ack   = 1'b0;
    wishbone_dat_r = 32'h0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd_rsp_dat", rsp_dat, 32'hDEADBEEF);
    check("rd_rsp_err", 32'(rsp_err), 32'h0);
    check("rd_cyc_off", 32'(wishbone_cyc), 32'h0);
    b0 = beats;
    take_rsp();
    check("rd_beats", 32'(beats - b0), 32'h1);
    check("rd_rv_off", 32'(rsp_valid), 32'h0);
    check("rd_cmd_ready", 32'(cmd_ready), 32'h1);

    // Write with immediate ack.
    send(1'b1, 30'h10, 32'h12345678, 4'b0011);
    check("wr_adr", 32'(wishbone_adr), 32'h10);
    check("wr_dat", wishbone_dat_w, 32'h12345678);
    check("wr_sel", 32'(wishbone_sel), 32'h3);
    check("wr_we", 32'(wishbone_we), 32'h1);
    wishbone_ack   = 1'b1;
    wishbone_dat_r = 32'hCAFEF00D;
    @(negedge clk);
    wishbone_ack = 1'b0;
    check("wr_cyc_off", 32'(wishbone_cyc), 32'h0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    take_rsp();

    // ack and err together: err wins.
    send(1'b0, 30'h20, 32'h0, 4'hF);
    wishbone_ack   = 1'b1;
    wishbone_err   = 1'b1;
    wishbone_dat_r = 32'hFFFFFFFF;
    @(negedge clk);
    wishbone_ack = 1'b0;
    wishbone_err = 1'b0;
    check("err_rsp_err", 32'(rsp_err), 32'h1);
    check("err_rsp_dat", rsp_dat, 32'h0);
    take_rsp();

    // Backpressure, with stray ack and cmd_valid during RESP.
    send(1'b0, 30'h3FFFFFFF, 32'h0, 4'hF);
    check("bp_adr_max", 32'(wishbone_adr), 32'h3FFFFFFF);
    wishbone_ack   = 1'b1;
    wishbone_dat_r = 32'hA5A55A5A;
    @(negedge clk);
    wishbone_dat_r = 32'h11111111;
    cmd_valid      = 1'b1;
    cmd_adr        = 30'h5;
    for (int i = 0; i < 5; i++) begin
      check("bp_rv", 32'(rsp_valid), 32'h1);
      check("bp_dat", rsp_dat, 32'hA5A55A5A);
      check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
      if (i < 4) @(negedge clk);
      wishbone_ack = 1'b0;
    end
    cmd_valid = 1'b0;
    take_rsp();
    check("bp_cmd_ready_after", 32'(cmd_ready), 32'h1);

    // Unanswered transfer.
    send(1'b0, 30'h40, 32'h0, 4'hF);
    ncyc = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 200 && wishbone_cyc; i++) begin
      ncyc++;
      @(negedge clk);
    end
    check("tmo_cyc_len", 32'(ncyc), 32'(TMO));
    check("tmo_rv", 32'(rsp_valid), 32'h1);
    check("tmo_flag", 32'(rsp_timeout), 32'h1);
    check("tmo_err", 32'(rsp_err), 32'h1);
    check("tmo_dat", rsp_dat, 32'h0);
    take_rsp();
    // ack on the last allowed cycle beats the timeout.
    send(1'b0, 30'h44, 32'h0, 4'hF);
    repeat (TMO - 1) @(negedge clk);
    wishbone_ack   = 1'b1;
    wishbone_dat_r = 32'h55;
    @(negedge clk);
    wishbone_ack = 1'b0;
    check("tmo_race_flag", 32'(rsp_timeout), 32'h0);
    check("tmo_race_err", 32'(rsp_err), 32'h0);
    check("tmo_race_dat", rsp_dat, 32'h55);
    take_rsp();
`else
    for (int i = 0; i < 100; i++) begin
      if (wishbone_cyc) ncyc++;
      @(negedge clk);
    end
    check("wait_cyc_len", 32'(ncyc), 32'd100);
    check("wait_cyc_still", 32'(wishbone_cyc), 32'h1);
    check("wait_rv", 32'(rsp_valid), 32'h0);
    wishbone_ack = 1'b1;
    @(negedge clk);
    wishbone_ack = 1'b0;
    check("wait_tmo_flag", 32'(rsp_timeout), 32'h0);
    take_rsp();
`endif

    // Reset mid-BUS discards the transfer.
    send(1'b0, 30'h80, 32'h0, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_cyc", 32'(wishbone_cyc), 32'h0);
    check("mrst_rv", 32'(rsp_valid), 32'h0);
    nrv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) nrv++;
    end
    check("mrst_no_rsp", 32'(nrv), 32'h0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Recovery transfer.
    send(1'b0, 30'h1234, 32'h0, 4'h1);
    wishbone_ack   = 1'b1;
    wishbone_dat_r = 32'h0BADF00D;
    @(negedge clk);
    wishbone_ack = 1'b0;
    check("rec_dat", rsp_dat, 32'h0BADF00D);
    take_rsp();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
